perf_event_trigger: RTL and testbench

PERF_EVENT_TRIGGER -- requirements
Module: perf_event_trigger

---
 rtl/perf_trig_pkg.sv | 9 +
 rtl/perf_trig_prio.sv | 40 ++++
 rtl/perf_event_trigger.sv | 113 +++++++++++
 tb/tb_perf_event_trigger.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_trig_pkg.sv
// perf_trig_pkg: shared state type and counter-slave address/data constants.
package perf_trig_pkg;
    typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_e;
    localparam int MAX_SECTIONS = 4;
    localparam int STOP_OFS = 0;
    localparam int GO_OFS = 1;
    localparam int SECTION_STRIDE = 4;
    localparam logic [31:0] CLR_DATA = 32'h1;
endpackage

// File: rtl/perf_trig_prio.sv
// perf_trig_prio: picks one pending request (clr, then stop, then go; lowest section first)
// and encodes its slave address and write data.
module perf_trig_prio
    import perf_trig_pkg::*;
#(
    parameter int N = MAX_SECTIONS
) (
    input  logic         clr_pend_i,
    input  logic [N-1:0] stop_pend_i,
    input  logic [N-1:0] go_pend_i,
    output logic         gnt_clr_o,
    output logic [N-1:0] gnt_stop_o,
    output logic [N-1:0] gnt_go_o,
    output logic [3:0]   addr_o,
    output logic [31:0]  data_o
);
    logic hit;
    always_comb begin
        gnt_clr_o = clr_pend_i;
        gnt_stop_o = '0;
        gnt_go_o = '0;
        addr_o = '0;
        data_o = clr_pend_i ? CLR_DATA : '0;
        hit = clr_pend_i;
        for (int i = 0; i < N; i++) begin
            if (!hit && stop_pend_i[i]) begin
                gnt_stop_o[i] = 1'b1;
                addr_o = 4'(i * SECTION_STRIDE + STOP_OFS);
                hit = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!hit && go_pend_i[i]) begin
                gnt_go_o[i] = 1'b1;
                addr_o = 4'(i * SECTION_STRIDE + GO_OFS);
                hit = 1'b1;
            end
        end
    end
endmodule

// File: rtl/perf_event_trigger.sv
// perf_event_trigger: turns start/stop/clear event pulses into single-word writes to a
// counter control slave, queuing one request per bit and counting events lost to collisions.
module perf_event_trigger
    import perf_trig_pkg::*;
#(
    parameter int NUM_SECTIONS = 4,
    parameter int DROP_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [NUM_SECTIONS-1:0] start_evt,
    input  logic [NUM_SECTIONS-1:0] stop_evt,
    input  logic                    clr_req,
    output logic [3:0]              avm_address,
    output logic                    avm_write,
    output logic                    avm_begintransfer,
    output logic [31:0]             avm_writedata,
    input  logic                    avm_waitrequest,
    output logic                    busy,
    output logic [DROP_W-1:0]       drop_count
);
    localparam int N = NUM_SECTIONS;
    localparam int SW = DROP_W + 4;

    state_e state_q, state_d;
    logic clr_q, clr_d, first_q;
    logic [N-1:0] go_q, go_d, stop_q, stop_d;
    logic [3:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic gnt_clr;
    logic [N-1:0] gnt_go, gnt_stop;
    logic [3:0] sel_addr;
    logic [31:0] sel_data;
    logic any_pend, sel, wipe, clr_keep, clr_drop;
    logic [N-1:0] ev_go, ev_stop, go_keep, stop_keep, go_drop, stop_drop;
    logic [SW-1:0] drop_sum, n_drop;

    perf_trig_prio #(.N(N)) u_prio (
        .clr_pend_i (clr_q),
        .stop_pend_i(stop_q),
        .go_pend_i  (go_q),
        .gnt_clr_o  (gnt_clr),
        .gnt_stop_o (gnt_stop),
        .gnt_go_o   (gnt_go),
        .addr_o     (sel_addr),
        .data_o     (sel_data)
    );

    assign any_pend = clr_q | (|go_q) | (|stop_q);
    assign sel = (state_q == IDLE) && any_pend;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = (state_q == IDLE) ? (any_pend ? WRITE : IDLE) : (avm_waitrequest ? WRITE : IDLE);
    end

    // A bit freed this edge (by selection or an accepted clear) takes a new event without a drop
    always_comb begin
        ev_go = enable ? start_evt : '0;
        ev_stop = enable ? stop_evt : '0;
        clr_keep = clr_q & ~(sel & gnt_clr);
        clr_drop = enable & clr_req & clr_keep;
        wipe = enable & clr_req & ~clr_keep;
        go_keep = wipe ? '0 : go_q & ~(sel ? gnt_go : '0);
        stop_keep = wipe ? '0 : stop_q & ~(sel ? gnt_stop : '0);
        go_drop = ev_go & go_keep;
        stop_drop = ev_stop & stop_keep;
        go_d = go_keep | ev_go;
        stop_d = stop_keep | ev_stop;
        clr_d = clr_keep | (enable & clr_req);
        addr_d = sel ? sel_addr : addr_q;
        data_d = sel ? sel_data : data_q;
        n_drop = SW'($countones({go_drop, stop_drop, clr_drop}));
        drop_sum = {4'b0, drop_q} + n_drop;
        drop_d = (|drop_sum[SW-1:DROP_W]) ? '1 : drop_sum[DROP_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clr_q <= 1'b0;
            go_q <= '0;
            stop_q <= '0;
            addr_q <= '0;
            data_q <= '0;
            drop_q <= '0;
            first_q <= 1'b0;
        end else begin
            clr_q <= clr_d;
            go_q <= go_d;
            stop_q <= stop_d;
            addr_q <= addr_d;
            data_q <= data_d;
            drop_q <= drop_d;
            first_q <= sel;
        end
    end

    always_comb begin
        avm_write = state_q == WRITE;
        avm_begintransfer = first_q;
        busy = (state_q == WRITE) | any_pend;
    end

    assign avm_address = addr_q;
    assign avm_writedata = data_q;
    assign drop_count = drop_q;
endmodule

// File: tb/tb_perf_event_trigger.sv
// tb_perf_event_trigger: scoreboard bench; a set-based reference model queues the writes it
// expects, and a negedge monitor compares every presented write and output against it.
module tb_perf_event_trigger;
    localparam int NS = 4;
    localparam int DW = 16;
    localparam int DMAX = (1 << DW) - 1;

    typedef struct {
        logic [3:0]  a;
        logic [31:0] d;
    } wr_t;

    logic clk = 1'b0, reset = 1'b1, enable = 1'b0, clr_req = 1'b0, wr_wait = 1'b0;
    logic [3:0] start_evt = '0, stop_evt = '0;
    logic [3:0] avm_address;
    logic avm_write, avm_begintransfer, busy;
    logic [31:0] avm_writedata;
    logic [DW-1:0] drop_count;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    perf_event_trigger #(.NUM_SECTIONS(NS), .DROP_W(DW)) dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .start_evt        (start_evt),
        .stop_evt         (stop_evt),
        .clr_req          (clr_req),
        .avm_address      (avm_address),
        .avm_write        (avm_write),
        .avm_begintransfer(avm_begintransfer),
        .avm_writedata    (avm_writedata),
        .avm_waitrequest  (wr_wait),
        .busy             (busy),
        .drop_count       (drop_count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int lowest(input bit [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic int sat_inc(input int x);
        return (x < DMAX) ? x + 1 : DMAX;
    endfunction

    // Reference model: pending requests as sets, at most one write in flight.
    bit m_clr, m_inwr, m_first;
    bit [3:0] m_go, m_stop;
    int m_drop, pn;
    wr_t w;
    wr_t exp_q[$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_clr = 0; m_go = 0; m_stop = 0; m_inwr = 0; m_first = 0; m_drop = 0;
            exp_q.delete();
        end else begin
            m_first = 0;
            if (m_inwr) m_inwr = wr_wait;
            else if (m_clr || m_stop != 0 || m_go != 0) begin
                if (m_clr) begin
                    w.a = 4'd0; w.d = 32'h1; m_clr = 0;
                end else if (m_stop != 0) begin
                    pn = lowest(m_stop); w.a = 4'(4 * pn); w.d = 32'h0; m_stop[pn] = 0;
                end else begin
                    pn = lowest(m_go); w.a = 4'(4 * pn + 1); w.d = 32'h0; m_go[pn] = 0;
                end
                exp_q.push_back(w);
                m_inwr = 1; m_first = 1;
            end
            if (enable) begin
                if (clr_req) begin
                    if (m_clr) m_drop = sat_inc(m_drop);
                    else begin m_clr = 1; m_go = 0; m_stop = 0; end
                end
                for (int n = 0; n < NS; n++) begin
                    if (stop_evt[n]) begin
                        if (m_stop[n]) m_drop = sat_inc(m_drop); else m_stop[n] = 1;
                    end
                    if (start_evt[n]) begin
                        if (m_go[n]) m_drop = sat_inc(m_drop); else m_go[n] = 1;
                    end
                end
            end
        end
    end

    // Monitor: logs of presented writes for the directed scenarios.
    wr_t cur;
    int idle_cnt = 0, wlen = 0, bt_cnt = 0;
    logic [3:0] log_a[$];
    logic [31:0] log_d[$];
    int log_len[$], log_gap[$];

    always @(negedge clk) begin
        if (!reset) begin
            chk("write", 32'(avm_write), 32'(m_inwr));
            chk("begintransfer", 32'(avm_begintransfer), 32'(m_first));
            chk("busy", 32'(busy), 32'(m_inwr || m_clr || m_go != 0 || m_stop != 0));
            chk("drop_count", 32'(drop_count), m_drop);
            if (avm_begintransfer) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_write: got addr %0d expected none", avm_address);
                end else begin
                    cur = exp_q.pop_front();
                    log_gap.push_back(idle_cnt);
                    log_a.push_back(avm_address);
                    log_d.push_back(avm_writedata);
                    idle_cnt = 0; wlen = 0; bt_cnt++;
                end
            end
            if (avm_write) begin
                wlen++;
                chk("address", 32'(avm_address), 32'(cur.a));
                chk("writedata", avm_writedata, cur.d);
                if (!wr_wait) log_len.push_back(wlen);
            end else idle_cnt++;
        end
    end

    task automatic step(input logic [3:0] s, input logic [3:0] p, input logic c);
        start_evt = s; stop_evt = p; clr_req = c;
        @(posedge clk); #2;
        start_evt = '0; stop_evt = '0; clr_req = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while ((busy || avm_write) && k < 300) begin step(0, 0, 0); k++; end
        chk("drain_in_budget", 32'(k < 300), 32'd1);
        step(0, 0, 0);
    endtask

    task automatic reset_outputs(input string tag);
        chk({tag, "_write"}, 32'(avm_write), 0);
        chk({tag, "_begin"}, 32'(avm_begintransfer), 0);
        chk({tag, "_addr"}, 32'(avm_address), 0);
        chk({tag, "_data"}, avm_writedata, 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_drops"}, 32'(drop_count), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1; wr_wait = 1'b0; enable = 1'b1;
        #1 reset_outputs("reset");
        @(posedge clk); #2;
        reset = 1'b0;
        log_a.delete(); log_d.delete(); log_len.delete(); log_gap.delete();
        idle_cnt = 0; bt_cnt = 0;
    endtask

    initial begin
        // single start on section 2: go write to address 9, one edge after sampling
        do_reset();
        step(4'b0100, 0, 0);
        chk("s1_not_yet", 32'(avm_write), 0);
        @(posedge clk); #2;
        chk("s1_write_now", 32'(avm_write), 1);
        chk("s1_addr", 32'(avm_address), 9);
        chk("s1_begin", 32'(avm_begintransfer), 1);
        drain();
        chk("s1_count", 32'(log_a.size()), 1);
        chk("s1_log_addr", 32'(log_a[0]), 9);
        chk("s1_log_data", log_d[0], 0);
        chk("s1_begin_cycles", 32'(bt_cnt), 1);

        // two stops under a 3-cycle stall: address 4 held 4 cycles, gap of 1, then 12
        do_reset();
        wr_wait = 1'b1;
        step(0, 4'b1010, 0);
        repeat (4) @(posedge clk);
        #2 wr_wait = 1'b0;
        drain();
        chk("s2_count", 32'(log_a.size()), 2);
        chk("s2_addr0", 32'(log_a[0]), 4);
        chk("s2_len0", 32'(log_len[0]), 4);
        chk("s2_addr1", 32'(log_a[1]), 12);
        chk("s2_gap", 32'(log_gap[1]), 1);

        // repeated start[0] during a stalled write: one drop, one extra write
        do_reset();
        wr_wait = 1'b1;
        step(4'b0001, 0, 0);
        step(4'b0001, 0, 0);
        step(4'b0001, 0, 0);
        chk("s3_drop", 32'(drop_count), 1);
        wr_wait = 1'b0;
        drain();
        chk("s3_count", 32'(log_a.size()), 2);
        chk("s3_addr0", 32'(log_a[0]), 1);
        chk("s3_addr1", 32'(log_a[1]), 1);

        // clear wipes older go[1] but keeps same-edge start[3]
        do_reset();
        wr_wait = 1'b1;
        step(4'b0001, 0, 0);
        step(4'b0010, 0, 0);
        step(4'b1000, 0, 1);
        wr_wait = 1'b0;
        drain();
        chk("s4_count", 32'(log_a.size()), 3);
        chk("s4_addr0", 32'(log_a[0]), 1);
        chk("s4_addr1", 32'(log_a[1]), 0);
        chk("s4_data1", log_d[1], 1);
        chk("s4_addr2", 32'(log_a[2]), 13);
        chk("s4_drop", 32'(drop_count), 0);

        // async reset in the middle of a stalled write
        do_reset();
        wr_wait = 1'b1;
        step(4'b0100, 0, 0);
        step(4'b0100, 0, 0);
        step(4'b0100, 0, 0);
        chk("s5_pre_write", 32'(avm_write), 1);
        chk("s5_pre_drop", 32'(drop_count), 1);
        #1 reset = 1'b1;
        #1 reset_outputs("s5_async");
        @(posedge clk); #2;
        reset = 1'b0; wr_wait = 1'b0;
        repeat (3) step(0, 0, 0);
        chk("s5_abandoned", 32'(avm_write), 0);

        // drop counter saturation
        do_reset();
        wr_wait = 1'b1;
        for (int i = 0; i < 7400; i++) step(4'hF, 4'hF, 1);
        chk("s6_saturated", 32'(drop_count), 32'hFFFF);
        wr_wait = 1'b0;
        drain();
        chk("s6_still_sat", 32'(drop_count), 32'hFFFF);

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            enable = ($urandom % 8) != 0;
            wr_wait = ($urandom % 3) == 0;
            step(4'($urandom) & 4'($urandom) & 4'($urandom),
                 4'($urandom) & 4'($urandom) & 4'($urandom),
                 ($urandom % 16) == 0);
        end
        wr_wait = 1'b0;
        drain();
        chk("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
